// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes and fetch-stage state encoding.
// Imported by the fetch stage and the control state machine.
package cpu_pkg;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 10;
  localparam int RS_MSB     = 9;
  localparam int RS_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  localparam logic [3:0] OP_MOVE1  = 4'b0000;
  localparam logic [3:0] OP_MOVE2  = 4'b0001;
  localparam logic [3:0] OP_MOVE3  = 4'b0010;
  localparam logic [3:0] OP_MOVE4  = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_AND    = 4'b0110;
  localparam logic [3:0] OP_OR     = 4'b0111;
  localparam logic [3:0] OP_LSHIFT = 4'b1000;
  localparam logic [3:0] OP_RSHIFT = 4'b1001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive cycles with run=1 and flags the cycle in which the LIMIT-th one occurs.
// Used by instr_fetch only when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign expired = run && (cnt == CNT_W'(LIMIT - 1));

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads one instruction per fetch pulse into IR and pulses ir_valid.
// Define FETCH_TIMEOUT_EN to add a request watchdog that raises the sticky fetch_err.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_fetch_pulse,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir,
  output logic [3:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [7:0]        offset_addr,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_overrun,
  output logic              fetch_err
);

  // The field slices below are fixed to a 16-bit instruction word.
  if (DATA_W != 16) begin : g_bad_data_w
    $error("instr_fetch: DATA_W must be 16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT_CYCLES must be at least 2");
  end

  fetch_state_e state, state_nxt;
  logic         load_ir;
  logic         timeout;
  logic         wd_expired;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      mem_addr      <= '0;
      ir            <= '0;
      fetch_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && en_fetch_pulse) mem_addr <= pc_addr;
      if (load_ir) ir <= mem_rdata;
      if (en_fetch_pulse && state != IDLE) fetch_overrun <= 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    load_ir   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: if (en_fetch_pulse) state_nxt = REQ;
      REQ: begin
        if (mem_ack) begin
          load_ir   = 1'b1;
          state_nxt = DONE;
        end else if (wd_expired) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  // An ack in the expiry cycle takes priority above, so the error only marks a real timeout.
  fetch_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE && en_fetch_pulse),
    .run    (state == REQ),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_err <= 1'b0;
    end else if (timeout) begin
      fetch_err <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign fetch_err  = 1'b0;
`endif

  assign mem_req     = (state == REQ);
  assign ir_valid    = (state == DONE);
  assign busy        = (state != IDLE);
  assign opcode      = ir[OPCODE_MSB:OPCODE_LSB];
  assign rd          = ir[RD_MSB:RD_LSB];
  assign rs          = ir[RS_MSB:RS_LSB];
  assign offset_addr = ir[IMM_MSB:IMM_LSB];

endmodule
